cga_comp_out: RTL and testbench

Output stage directly downstream of the CGA composite generator. Consumes the 7-bit composite level and the separated hsync/vsync pulses. Registers the level for the parallel R-2R DAC and also produces a 1-bit first-order delta-sigma stream for boards with a single RC-filtered pin. A sync-lock supervisor forces blank level when horizontal sync is missing or malformed, so a monitor never sees a sync-less signal; it also reports lines per field.

---
 rtl/cga_comp_pkg.sv | 18 +
 rtl/cga_sd_mod.sv | 25 ++
 rtl/cga_comp_out.sv | 131 +++++++++++++
 tb/tb_cga_comp_out.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_comp_pkg.sv
// Shared types and defaults for the CGA composite output stage.
// Widths here size the period counter and per-field line counter.
package cga_comp_pkg;
  typedef enum logic [1:0] {
    LOST,
    ACQUIRE,
    LOCKED
  } state_e;

  localparam int PER_W  = 11;
  localparam int LINE_W = 9;

  localparam logic [6:0] BLANK_DEF = 7'd29;
  localparam int LINE_MIN_DEF      = 1792;
  localparam int LINE_MAX_DEF      = 1856;
  localparam int HSYNC_TMO_DEF     = 2047;
  localparam int LOCK_COUNT_DEF    = 2;
endpackage

// File: rtl/cga_sd_mod.sv
// First-order delta-sigma modulator: 7-bit level to a 1-bit stream
// whose ones density is level/128.
module cga_sd_mod (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] level,
  output logic       sd_out
);
  logic [6:0] r_res;
  logic       r_sd;
  logic [7:0] w_sum;

  assign w_sum  = {1'b0, r_res} + {1'b0, level};
  assign sd_out = r_sd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res <= '0;
      r_sd  <= 1'b0;
    end else begin
      r_res <= w_sum[6:0];
      r_sd  <= w_sum[7];
    end
  end
endmodule

// File: rtl/cga_comp_out.sv
// CGA composite output stage: registered DAC level, delta-sigma pin,
// hsync lock supervisor that blanks on sync loss, and line counter.
module cga_comp_out
  import cga_comp_pkg::*;
#(
  parameter logic [6:0] BLANK_LEVEL   = BLANK_DEF,
  parameter int         LINE_MIN      = LINE_MIN_DEF,
  parameter int         LINE_MAX      = LINE_MAX_DEF,
  parameter int         HSYNC_TIMEOUT = HSYNC_TMO_DEF,
  parameter int         LOCK_COUNT    = LOCK_COUNT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        comp_video,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              enable,
  output logic [6:0]        dac_out,
  output logic              sd_out,
  output logic              signal_ok,
  output logic [LINE_W-1:0] line_count
);
  localparam logic [PER_W-1:0] P_MIN = PER_W'(LINE_MIN);
  localparam logic [PER_W-1:0] P_MAX = PER_W'(LINE_MAX);
  localparam logic [PER_W-1:0] P_TMO = PER_W'(HSYNC_TIMEOUT);
  localparam logic [1:0]       G_LCK = 2'(LOCK_COUNT);

  logic [6:0]        r_video;
  logic              r_hs, r_hs_d;
  logic              r_vs, r_vs_d;
  logic [PER_W-1:0]  r_per;
  logic [1:0]        r_good;
  state_e            r_state;
  logic [6:0]        r_dac;
  logic              r_ok;
  logic [LINE_W-1:0] r_acc;
  logic [LINE_W-1:0] r_lines;

  logic       w_hs_rise, w_vs_rise;
  logic       w_per_ok, w_tmo;
  logic [1:0] w_good_inc;
  logic [1:0] w_good_nxt;
  state_e     w_state_nxt;

  assign w_hs_rise  = r_hs & ~r_hs_d;
  assign w_vs_rise  = r_vs & ~r_vs_d;
  assign w_per_ok   = (r_per >= P_MIN) && (r_per <= P_MAX);
  assign w_tmo      = (r_per == P_TMO) && !w_hs_rise;
  assign w_good_inc = r_good + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (w_tmo) begin
      w_state_nxt = LOST;
      w_good_nxt  = '0;
    end else if (w_hs_rise) begin
      unique case (r_state)
        LOST: begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = '0;
        end
        ACQUIRE: begin
          if (w_per_ok) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == G_LCK) w_state_nxt = LOCKED;
          end else begin
            w_good_nxt = '0;
          end
        end
        LOCKED: begin
          if (!w_per_ok) begin
            w_state_nxt = ACQUIRE;
            w_good_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = LOST;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_video <= '0;
      r_hs    <= 1'b0;
      r_hs_d  <= 1'b0;
      r_vs    <= 1'b0;
      r_vs_d  <= 1'b0;
      r_per   <= '0;
      r_good  <= '0;
      r_state <= LOST;
      r_dac   <= BLANK_LEVEL;
      r_ok    <= 1'b0;
      r_acc   <= '0;
      r_lines <= '0;
    end else begin
      r_video <= comp_video;
      r_hs    <= hsync_in;
      r_hs_d  <= r_hs;
      r_vs    <= vsync_in;
      r_vs_d  <= r_vs;
      if (w_hs_rise) r_per <= PER_W'(1);
      else if (r_per != P_TMO) r_per <= r_per + 1'b1;
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      // ok and dac follow the next state so both change on the same edge
      r_ok    <= (w_state_nxt == LOCKED);
      r_dac   <= (w_state_nxt == LOCKED && enable) ? r_video : BLANK_LEVEL;
      if (w_vs_rise) begin
        r_lines <= r_acc;
        r_acc   <= w_hs_rise ? LINE_W'(1) : '0;
      end else if (w_hs_rise && r_acc != '1) begin
        r_acc <= r_acc + 1'b1;
      end
    end
  end

  cga_sd_mod u_sd (
    .clk    (clk),
    .reset  (reset),
    .level  (r_dac),
    .sd_out (sd_out)
  );

  assign dac_out    = r_dac;
  assign signal_ok  = r_ok;
  assign line_count = r_lines;
endmodule

// File: tb/tb_cga_comp_out.sv
// Scoreboard bench for cga_comp_out: directed sync/video vectors push
// expected outputs tagged with a cycle; a monitor checks them.
module tb_cga_comp_out;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] comp_video;
  logic       hsync_in;
  logic       vsync_in;
  logic       enable;
  logic [6:0] dac_out;
  logic       sd_out;
  logic       signal_ok;
  logic [8:0] line_count;

  cga_comp_out dut (
    .clk        (clk),
    .reset      (reset),
    .comp_video (comp_video),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .enable     (enable),
    .dac_out    (dac_out),
    .sd_out     (sd_out),
    .signal_ok  (signal_ok),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_DAC = 0;
  localparam int S_OK  = 1;
  localparam int S_LC  = 2;
  localparam int S_SD  = 3;
  localparam int S_DEN = 4;

  typedef struct {
    int    t_at;
    int    sig;
    int    val;
    string nm;
  } item_t;

  item_t        sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] sd_hist = '0;

  task automatic expect_at(int t, int sig, int val, string nm);
    item_t it;
    it.t_at = t;
    it.sig  = sig;
    it.val  = val;
    it.nm   = nm;
    sbq.push_back(it);
  endtask

  initial begin
    int act;
    forever begin
      @(negedge clk);
      sd_hist = {sd_hist[126:0], sd_out};
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].t_at <= cyc) begin
          case (sbq[i].sig)
            S_DAC:   act = int'(dac_out);
            S_OK:    act = int'(signal_ok);
            S_LC:    act = int'(line_count);
            S_SD:    act = int'(sd_out);
            default: act = $countones(sd_hist);
          endcase
          checks++;
          if (sbq[i].t_at < cyc) begin
            errors++;
            $display("FAIL %s: check for cyc %0d missed (now %0d)",
                     sbq[i].nm, sbq[i].t_at, cyc);
          end else if (act != sbq[i].val) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d",
                     sbq[i].nm, cyc, act, sbq[i].val);
          end
          sbq.delete(i);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hs_on();
    hsync_in = 1'b1;
    step(1);
    hsync_in = 1'b0;
  endtask

  task automatic hs(int p);
    hs_on();
    step(p - 1);
  endtask

  task automatic rnd_inputs();
    comp_video = 7'($urandom);
    hsync_in   = 1'($urandom);
    vsync_in   = 1'($urandom);
    enable     = 1'($urandom);
  endtask

  task automatic dens_line(int lvl, bit en, int dens);
    int v;
    hs_on();
    step(9);
    v = cyc;
    comp_video = 7'(lvl);
    enable     = en;
    expect_at(v + 400, S_DEN, dens, "sd_density");
    expect_at(v + 400, S_DAC, en ? lvl : 29, "dac_level");
    step(1824 - 10);
  endtask

  task automatic vs_pulse(bit with_hs, int lc, bit chk);
    if (chk) expect_at(cyc + 2, S_LC, lc, "line_count");
    vsync_in = 1'b1;
    hsync_in = with_hs;
    step(1);
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    step(3);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    rnd_inputs();
    repeat (4) begin
      step(1);
      rnd_inputs();
    end
    reset      = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    comp_video = 7'd100;
    enable     = 1'b1;
    c = cyc;
    expect_at(c, S_DAC, 29, "rst_dac");
    expect_at(c, S_OK, 0, "rst_ok");
    expect_at(c, S_LC, 0, "rst_lc");
    expect_at(c, S_SD, 0, "rst_sd");
    expect_at(c + 1, S_DAC, 29, "post_rst_dac");
    step(20);

    // acquire: third rise locks
    hs(1824);
    hs(1824);
    c = cyc;
    expect_at(c + 1, S_OK, 0, "lock_ok_pre");
    expect_at(c + 2, S_OK, 1, "lock_ok");
    expect_at(c + 1, S_DAC, 29, "lock_dac_pre");
    expect_at(c + 2, S_DAC, 100, "lock_dac");
    hs(1824);

    hs_on();
    step(99);
    c = cyc;
    comp_video = 7'd55;
    expect_at(c + 1, S_DAC, 100, "lat_dac_old");
    expect_at(c + 2, S_DAC, 55, "lat_dac_new");
    step(1724);

    // sync loss
    c = cyc;
    expect_at(c + 2048, S_OK, 1, "tmo_ok_pre");
    expect_at(c + 2049, S_OK, 0, "tmo_ok");
    expect_at(c + 2048, S_DAC, 55, "tmo_dac_pre");
    expect_at(c + 2049, S_DAC, 29, "tmo_dac");
    hs(2200);
    hs(1824);
    hs(1824);
    c = cyc;
    expect_at(c + 1, S_OK, 0, "relock_ok_pre");
    expect_at(c + 2, S_OK, 1, "relock_ok");
    expect_at(c + 2, S_DAC, 55, "relock_dac");
    hs(1600);

    c = cyc;
    expect_at(c + 1, S_OK, 1, "short_ok_pre");
    expect_at(c + 2, S_OK, 0, "short_ok");
    expect_at(c + 2, S_DAC, 29, "short_dac");
    hs(1824);
    hs(1824);
    c = cyc;
    expect_at(c + 2, S_OK, 1, "short_relock");
    hs(1856);
    c = cyc;
    expect_at(c + 2, S_OK, 1, "line_max_ok");
    hs(1857);
    c = cyc;
    expect_at(c + 2, S_OK, 0, "line_max1_rej");
    hs(1792);
    c = cyc;
    expect_at(c + 2, S_OK, 0, "line_min_good1");
    hs(1792);
    c = cyc;
    expect_at(c + 2, S_OK, 1, "line_min_lock");
    hs(1791);
    c = cyc;
    expect_at(c + 2, S_OK, 0, "line_min1_rej");
    hs(1824);
    hs(1824);
    c = cyc;
    expect_at(c + 2, S_OK, 1, "pre_dens_lock");

    dens_line(64, 1'b1, 64);
    dens_line(0, 1'b1, 0);
    dens_line(127, 1'b1, 127);
    dens_line(100, 1'b0, 29);

    // reset mid-operation while locked
    hs_on();
    step(9);
    c = cyc;
    comp_video = 7'd90;
    enable     = 1'b1;
    expect_at(c + 2, S_DAC, 90, "pre_mid_dac");
    expect_at(c + 2, S_OK, 1, "pre_mid_ok");
    step(100);
    c = cyc;
    reset = 1'b1;
    expect_at(c + 1, S_DAC, 29, "mid_rst_dac");
    expect_at(c + 1, S_OK, 0, "mid_rst_ok");
    expect_at(c + 1, S_SD, 0, "mid_rst_sd");
    expect_at(c + 1, S_LC, 0, "mid_rst_lc");
    step(1);
    reset = 1'b0;
    step(50);

    // line counting
    repeat (3) hs(4);
    vs_pulse(1'b0, 3, 1'b1);
    repeat (262) hs(4);
    vs_pulse(1'b0, 262, 1'b1);
    repeat (5) hs(4);
    vs_pulse(1'b1, 5, 1'b1);
    repeat (3) hs(4);
    vs_pulse(1'b0, 4, 1'b1);
    repeat (600) hs(4);
    vs_pulse(1'b0, 511, 1'b1);
    step(10);

    foreach (sbq[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: pending check for cyc %0d never reached",
               sbq[i].nm, sbq[i].t_at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by cyc %0d expected under 100000",
             cyc);
    $fatal(1, "watchdog");
  end
endmodule
